// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions used by the instruction fetch unit.
package instr_fetch_unit_pkg;

  // Default fetch parameters
  localparam int unsigned IFU_PC_W     = 8;
  localparam int unsigned IFU_RESET_PC = 0;
  localparam logic [3:0]  IFU_HALT_OPC = 4'hF;

  // Instruction word layout: {opcode[15:12], rd, rs1, rs2}
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OPC_W   = 4;

  // Fetch FSM encoding
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Extract the opcode field from an instruction word
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Two-entry buffer for fetched {instruction, pc} pairs with synchronous flush.
module fetch_fifo #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [1:0][W-1:0] mem_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  // Storage, pointers and occupancy; flush drops everything buffered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads, buffers responses, delivers
// them downstream with a valid/ready handshake, halts on HALT_OPC.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = IFU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC),
  parameter logic [3:0]      HALT_OPC = IFU_HALT_OPC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic                inflight_q, inflight_d;
  logic                req_c;
  logic                push_c;
  logic                pop_c;
  logic                flush_c;
  logic                halt_hit_c;
  logic                full_c;
  logic                empty_c;
  logic [1:0]          occ_c;
  logic [2:0]          load_c;
  logic [ENTRY_W-1:0]  head_c;

  // Buffered count, and the load left after this cycle's transfer
  assign occ_c      = full_c ? 2'd2 : (empty_c ? 2'd0 : 2'd1);
  assign pop_c      = instr_valid && instr_ready && !redirect_valid;
  assign load_c     = 3'(occ_c) + 3'(inflight_q) - 3'(pop_c);
  assign halt_hit_c = inflight_q && (opcode_of(imem_rdata) == HALT_OPC);

  assign imem_req    = req_c && rst_n;
  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign instr_valid = !empty_c;
  assign instr       = head_c[PC_W +: INSTR_W];
  assign instr_pc    = head_c[PC_W-1:0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and issue control; redirect overrides capture, transfer and halt
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    inflight_d = 1'b0;
    req_c      = 1'b0;
    push_c     = 1'b0;
    flush_c    = 1'b0;
    if (redirect_valid) begin
      flush_c = 1'b1;
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else begin
      push_c = inflight_q;
      if (halt_hit_c) begin
        state_d = ST_HALT;
      end
      // Nothing past a HALT word is ever fetched
      if ((state_q == ST_RUN) && !halt_hit_c && (load_c < 3'd2)) begin
        req_c      = 1'b1;
        pc_d       = pc_q + PC_W'(1);
        addr_d     = pc_q;
        inflight_d = 1'b1;
      end
    end
  end

  // PC, in-flight flag and the address of the outstanding read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .data_i  ({imem_rdata, addr_q}),
    .pop_i   (pop_c),
    .flush_i (flush_c),
    .data_o  (head_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected delivery stream is rebuilt
// from memory contents on every reset/redirect; a negedge monitor checks it.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        halted;

  logic        imem_req2;
  logic [7:0]  imem_addr2;
  logic [15:0] imem_rdata2 = 16'h0;
  logic        redirect_valid2;
  logic [7:0]  redirect_pc2;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [15:0] instr2;
  logic [7:0]  instr_pc2;
  logic        halted2;

  logic [15:0] mem [256];
  logic [23:0] expq [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          epoch    = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .HALT_OPC(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .halted(halted)
  );

  instr_fetch_unit #(.PC_W(8), .RESET_PC(8'hFE), .HALT_OPC(4'hF)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr(instr2),
    .instr_pc(instr_pc2), .halted(halted2)
  );

  // Synchronous memories: data one cycle after the request
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];
  always @(posedge clk) if (imem_req2) imem_rdata2 <= 16'h0100 | {8'h00, imem_addr2};

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Expected stream after a restart at 'start': sequential words through the first HALT word
  function automatic void build(input logic [7:0] start);
    logic [7:0] a;
    a = start;
    expq.delete();
    for (int i = 0; i < 512; i++) begin
      expq.push_back({mem[a], a});
      if (mem[a][15:12] == 4'hF) break;
      a = a + 8'd1;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse inside a cycle; outputs must clear at once
  task automatic reset_pulse();
    #1;
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    epoch++;
    #1;
    chk_eq("reset_ctrl", 32'({instr_valid, imem_req, halted, imem_addr}), 32'h0);
    chk_eq("reset_instr", 32'({instr, instr_pc}), 32'h0);
    build(8'h00);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard pops on each transfer, plus hold/occupancy/halt invariants
  logic [23:0] e;
  logic [15:0] prev_instr;
  logic [7:0]  prev_pc;
  bit          prev_stall = 1'b0;
  int          outstanding = 0;
  int          mon_epoch = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (epoch != mon_epoch) begin
        mon_epoch   = epoch;
        outstanding = 0;
        prev_stall  = 1'b0;
      end
      if (rst_n) begin
        if (prev_stall)
          chk_eq("stall_hold", 32'({instr_valid, instr, instr_pc}), 32'({1'b1, prev_instr, prev_pc}));
        if (imem_req) outstanding++;
        if (instr_valid && instr_ready && !redirect_valid) begin
          outstanding--;
          n_checks++;
          if (expq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_xfer: got pc %h instr %h, required no delivery", instr_pc, instr);
          end else begin
            e = expq.pop_front();
            n_checks--;
            chk_eq("xfer", 32'({instr, instr_pc}), 32'(e));
          end
        end
        chk_eq("outstanding_le2", 32'(outstanding <= 2), 32'd1);
        if (halted) chk_eq("halt_no_req", 32'(imem_req), 32'd0);
        prev_stall = instr_valid && !instr_ready && !redirect_valid;
        prev_instr = instr;
        prev_pc    = instr_pc;
        if (redirect_valid) outstanding = 0;
      end
    end
  end

  // Second instance: pc wraps FE, FF, 00, 01 after reset
  int         k2 = 0;
  logic [7:0] e2;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid2 && k2 < 4) begin
        e2 = 8'hFE + 8'(k2);
        chk_eq("wrap_seq", 32'({instr2, instr_pc2}), 32'({16'h0100 | {8'h00, e2}, e2}));
        k2++;
      end
    end
  end

  int r;
  initial begin
    rst_n           = 1'b0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 8'h00;
    instr_ready2    = 1'b1;
    redirect_valid2 = 1'b0;
    redirect_pc2    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 | 16'(i);

    repeat (3) cyc();
    chk_eq("reset_ctrl", 32'({instr_valid, imem_req, halted, imem_addr}), 32'h0);
    chk_eq("reset_instr", 32'({instr, instr_pc}), 32'h0);
    chk_eq("reset_addr2", 32'(imem_addr2), 32'h0000_00FE);

    // Release reset: first read at 0, first delivery two cycles later
    build(8'h00);
    epoch++;
    rst_n = 1'b1;
    #1;
    chk_eq("first_req", 32'({imem_req, imem_addr}), 32'h0000_0100);
    cyc();
    chk_eq("cycle1", 32'({imem_req, imem_addr, instr_valid}), 32'({1'b1, 8'h01, 1'b0}));
    cyc();
    chk_eq("cycle2", 32'({instr_valid, instr_pc, imem_addr}), 32'({1'b1, 8'h00, 8'h02}));
    cyc();
    chk_eq("cycle3", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h01}));
    repeat (10) cyc();

    // Downstream stall for 5 cycles
    instr_ready = 1'b0;
    cyc();
    cyc();
    chk_eq("stall_no_req", 32'({imem_req, instr_valid}), 32'({1'b0, 1'b1}));
    repeat (3) cyc();
    instr_ready = 1'b1;
    repeat (10) cyc();

    // Asynchronous reset while a word is being presented
    chk_eq("valid_before_pulse", 32'(instr_valid), 32'd1);
    reset_pulse();
    #1;
    chk_eq("restart_req", 32'({imem_req, imem_addr, instr_valid}), 32'({1'b1, 8'h00, 1'b0}));
    repeat (10) cyc();

    // Redirect with a full buffer
    instr_ready = 1'b0;
    repeat (4) cyc();
    chk_eq("buffered_before_redirect", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    build(8'h40);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk_eq("redirect_req", 32'({imem_req, imem_addr, instr_valid}), 32'({1'b1, 8'h40, 1'b0}));
    instr_ready = 1'b1;
    repeat (10) cyc();

    // HALT word at address 5
    mem[5] = 16'hF000;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    build(8'h00);
    cyc();
    redirect_valid = 1'b0;
    repeat (20) cyc();
    chk_eq("halted", 32'({halted, imem_req}), 32'({1'b1, 1'b0}));
    chk_eq("halt_drained", 32'(expq.size()), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    build(8'h00);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk_eq("resume", 32'({halted, imem_req, imem_addr}), 32'({1'b0, 1'b1, 8'h00}));
    repeat (20) cyc();
    chk_eq("halted_again", 32'(halted), 32'd1);
    mem[5] = 16'h0105;

    // Randomized traffic: stalls, redirects, reset pulses, random HALT words
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    reset_pulse();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      redirect_valid = 1'b0;
      instr_ready    = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom);
        build(redirect_pc);
      end else if (r == 4) begin
        reset_pulse();
      end
    end
    cyc();
    redirect_valid = 1'b0;
    repeat (5) cyc();
    chk_eq("wrap_count", 32'(k2), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning instruction-word address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-003 SHALL have parameter HALT_OPC, default 4'hF, meaning the instr[15:12] opcode that stops fetching.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port imem_req, output, 1, meaning a read is issued this cycle.
REQ-007 SHALL have port imem_addr, output, PC_W, meaning the word address of the read.
REQ-008 SHALL have port imem_rdata, input, 16, meaning read data, valid exactly 1 cycle after imem_req.
REQ-009 SHALL have port redirect_valid, input, 1, meaning branch/jump redirect request.
REQ-010 SHALL have port redirect_pc, input, PC_W, meaning the redirect target.
REQ-011 SHALL have port instr_valid, output, 1, meaning instr and instr_pc hold a deliverable instruction.
REQ-012 SHALL have port instr_ready, input, 1, meaning the downstream RISC_Processor accepts this cycle.
REQ-013 SHALL have port instr, output, 16, meaning the instruction word {opcode[15:12], rd, rs1, rs2}.
REQ-014 SHALL have port instr_pc, output, PC_W, meaning the address instr was fetched from.
REQ-015 SHALL have port halted, output, 1, meaning the fetch FSM is in HALT.

Function
REQ-016 SHALL implement FSM states RUN and HALT; reset enters RUN.
REQ-017 In RUN, SHALL assert imem_req with imem_addr=pc only when (buffered + in-flight) < 2, then increment pc.
REQ-018 SHALL capture imem_rdata together with its issue address into a 2-entry FIFO one cycle after issue.
REQ-019 SHALL drive instr_valid/instr/instr_pc from the FIFO head; a transfer occurs when instr_valid && instr_ready.
REQ-020 SHALL hold instr and instr_pc stable while instr_valid && !instr_ready.
REQ-021 SHALL sustain one instruction per cycle when instr_ready stays high (issue-to-instr_valid latency 2 cycles).
REQ-022 SHALL increment pc modulo 2^PC_W; the address after all-ones SHALL be 0.
REQ-023 When a captured word has instr[15:12]==HALT_OPC, SHALL enter HALT, stop issuing, and still deliver that word.
REQ-024 On redirect_valid, SHALL flush the FIFO, discard the in-flight response, set pc=redirect_pc, and enter RUN.
REQ-025 The first request after a redirect SHALL be issued in the cycle following redirect_valid.
REQ-026 Redirect SHALL win over a simultaneous capture, a downstream transfer, or HALT entry in the same cycle.
REQ-027 The halted output SHALL equal (state==HALT).

Reset
REQ-028 On rst_n low, SHALL immediately clear all outputs: instr_valid=0, instr=0, instr_pc=0, imem_req=0, imem_addr=RESET_PC, halted=0.
REQ-029 On rst_n low, SHALL empty the FIFO, drop any in-flight read, and set pc=RESET_PC.
REQ-030 On the first clk edge after rst_n rises, SHALL issue a read at RESET_PC.
REQ-031 A reset asserted mid-stream SHALL lose all buffered instructions with no partial transfer.

Structure
REQ-032 SHALL place PC_W, RESET_PC, HALT_OPC defaults, the state encoding, and the opcode field position in the shared processor package.
REQ-033 SHALL implement the 2-entry buffer as sub-module fetch_fifo: 16+PC_W wide, push/pop/flush, full/empty outputs.

Verification
REQ-034 Reset release with instr_ready=1 and memory word n = 16'h01nn -> imem_addr 0,1,2...; instr_pc 0,1,2... one per cycle from cycle 2.
REQ-035 Drop instr_ready for 5 cycles mid-stream -> at most 2 words buffered, imem_req low, no word lost or duplicated, instr stable.
REQ-036 Redirect to 8'h40 while 2 words are buffered -> those words never appear; the next instr_pc is 8'h40.
REQ-037 Word 16'hF000 at address 5 -> delivered with instr_pc=5, then halted=1 with no further imem_req; a later redirect to 0 resumes RUN.
REQ-038 Set RESET_PC=8'hFE with instr_ready=1 -> instr_pc sequence FE, FF, 00, 01.
REQ-039 Pulse rst_n low while instr_valid=1 -> instr_valid=0 immediately (asynchronous), and fetch restarts at RESET_PC.
